// File: rtl/adc_scale_bcd.sv
// rtl/adc_scale_bcd.sv - multi-channel ADC code to packed-BCD scaler with per-channel result bank
//
// Converts one raw ADC code at a time to floor(code*FULL_SCALE/(2^ADC_W-1)).
// A restoring divider produces the quotient, and a shift-add-3 pass converts it
// to packed BCD. The last result of every channel is kept for the display logic.
//
// Ports:
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready      sample handshake; in_ready is high only while idle
//   in_chan, in_data       channel index and raw ADC code of the sample
//   out_valid              one-cycle pulse when a result completes
//   out_chan, out_bcd      channel and packed BCD (digit 0 in [3:0]) of that result
//   out_ovf                result did not fit in NUM_DIGITS digits (out_bcd is all 9s)
//   rd_chan                bank read select
//   rd_bcd, rd_ovf         combinational read of the bank; 0 for rd_chan >= CHANNELS

module adc_scale_bcd #(
    parameter int  ADC_W      = 12,
    parameter int  FULL_SCALE = 500000,
    parameter int  NUM_DIGITS = 6,
    parameter int  CHANNELS   = 8,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CH_W-1:0]         in_chan,
    input  logic [ADC_W-1:0]        in_data,
    output logic                    out_valid,
    output logic [CH_W-1:0]         out_chan,
    output logic [4*NUM_DIGITS-1:0] out_bcd,
    output logic                    out_ovf,
    input  logic [CH_W-1:0]         rd_chan,
    output logic [4*NUM_DIGITS-1:0] rd_bcd,
    output logic                    rd_ovf
);

    localparam int Q_W   = $clog2(FULL_SCALE + 1);
    localparam int P_W   = ADC_W + Q_W;
    localparam int OUT_W = 4 * NUM_DIGITS;
    // One spare digit above the output width so an oversize result is visible.
    localparam int BCD_W = 4 * (NUM_DIGITS + 1);
    localparam int CNT_W = $clog2(P_W);

    localparam logic [P_W-1:0]   DIVISOR     = {{Q_W{1'b0}}, {ADC_W{1'b1}}};
    localparam logic [ADC_W:0]   DIV_SHORT   = DIVISOR[ADC_W:0];
    localparam logic [P_W-1:0]   SCALE       = P_W'(FULL_SCALE);
    localparam logic [CNT_W-1:0] CNT_DIV_TOP = CNT_W'(P_W - 1);
    localparam logic [CNT_W-1:0] CNT_BCD_TOP = CNT_W'(Q_W - 1);
    localparam logic [OUT_W-1:0] ALL_NINES   = {NUM_DIGITS{4'h9}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_BCD,
        ST_DONE
    } state_t;

    state_t             state;
    logic [CH_W-1:0]    lat_chan;
    logic [ADC_W-1:0]   lat_data;
    logic [P_W-1:0]     prod;
    logic [ADC_W-1:0]   rem;
    logic [P_W-1:0]     quot;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]   bcd;
    logic               bcd_lost;

    logic [OUT_W-1:0]   bank_bcd [CHANNELS];
    logic [CHANNELS-1:0] bank_ovf;

    // Divider step. The remainder is always below the divisor, so ADC_W bits
    // hold it and one extra bit covers the shifted trial value.
    logic [ADC_W:0]     trial;
    logic               trial_ge;
    logic [ADC_W-1:0]   rem_next;

    always_comb begin
        trial    = {rem, prod[cnt]};
        trial_ge = (trial >= DIV_SHORT);
        rem_next = trial_ge ? ADC_W'(trial - DIV_SHORT) : trial[ADC_W-1:0];
    end

    // Add-3 correction applied to every digit before the shift.
    logic [BCD_W-1:0]   bcd_adj;

    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < NUM_DIGITS + 1; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // bcd_lost catches a digit shifted out of the spare digit, so the overflow
    // flag stays correct even when Q_W is large relative to NUM_DIGITS.
    logic               res_ovf;
    logic [OUT_W-1:0]   res_bcd;
    logic               lat_in_range;

    always_comb begin
        res_ovf      = (bcd[BCD_W-1 -: 4] != 4'h0) || bcd_lost || (|quot[P_W-1:Q_W]);
        res_bcd      = res_ovf ? ALL_NINES : bcd[OUT_W-1:0];
        lat_in_range = (32'(lat_chan) < CHANNELS);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_chan  <= '0;
            out_bcd   <= '0;
            out_ovf   <= 1'b0;
            lat_chan  <= '0;
            lat_data  <= '0;
            prod      <= '0;
            rem       <= '0;
            quot      <= '0;
            cnt       <= '0;
            bcd       <= '0;
            bcd_lost  <= 1'b0;
            bank_ovf  <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                bank_bcd[k] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        lat_chan <= in_chan;
                        lat_data <= in_data;
                        in_ready <= 1'b0;
                        state    <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    prod  <= {{Q_W{1'b0}}, lat_data} * SCALE;
                    rem   <= '0;
                    quot  <= '0;
                    cnt   <= CNT_DIV_TOP;
                    state <= ST_DIV;
                end
                ST_DIV: begin
                    rem  <= rem_next;
                    quot <= {quot[P_W-2:0], trial_ge};
                    if (cnt == '0) begin
                        cnt      <= CNT_BCD_TOP;
                        bcd      <= '0;
                        bcd_lost <= 1'b0;
                        state    <= ST_BCD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_BCD: begin
                    bcd      <= {bcd_adj[BCD_W-2:0], quot[cnt]};
                    bcd_lost <= bcd_lost | bcd_adj[BCD_W-1];
                    if (cnt == '0) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    out_valid <= 1'b1;
                    out_chan  <= lat_chan;
                    out_bcd   <= res_bcd;
                    out_ovf   <= res_ovf;
                    // Out-of-range channels are reported but never banked.
                    if (lat_in_range) begin
                        bank_bcd[lat_chan] <= res_bcd;
                        bank_ovf[lat_chan] <= res_ovf;
                    end
                    in_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    logic rd_in_range;

    always_comb begin
        rd_in_range = (32'(rd_chan) < CHANNELS);
        rd_bcd      = rd_in_range ? bank_bcd[rd_chan] : '0;
        rd_ovf      = rd_in_range ? bank_ovf[rd_chan] : 1'b0;
    end

endmodule

// File: tb/tb_adc_scale_bcd.sv
// tb/tb_adc_scale_bcd.sv - self-checking bench for adc_scale_bcd

module tb_adc_scale_bcd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic [1:0]      i_valid;
    logic [1:0][2:0] i_chan;
    logic [1:0][11:0] i_data;
    logic [1:0][2:0] rd_chan;

    // dut0: default parameters. dut1: NUM_DIGITS=5, CHANNELS=6.
    logic        rdy0, vld0, ovf0, rovf0;
    logic [2:0]  ch0;
    logic [23:0] bcd0, rbcd0;
    logic        rdy1, vld1, ovf1, rovf1;
    logic [2:0]  ch1;
    logic [19:0] bcd1, rbcd1;

    logic [1:0]       o_ready, o_valid, o_ovf, r_ovf;
    logic [1:0][2:0]  o_chan;
    logic [1:0][23:0] o_bcd, r_bcd;

    assign o_ready = {rdy1, rdy0};
    assign o_valid = {vld1, vld0};
    assign o_ovf   = {ovf1, ovf0};
    assign r_ovf   = {rovf1, rovf0};
    assign o_chan  = {ch1, ch0};
    assign o_bcd   = {{4'h0, bcd1}, bcd0};
    assign r_bcd   = {{4'h0, rbcd1}, rbcd0};

    adc_scale_bcd dut0 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(i_valid[0]), .in_ready(rdy0), .in_chan(i_chan[0]), .in_data(i_data[0]),
        .out_valid(vld0), .out_chan(ch0), .out_bcd(bcd0), .out_ovf(ovf0),
        .rd_chan(rd_chan[0]), .rd_bcd(rbcd0), .rd_ovf(rovf0)
    );

    adc_scale_bcd #(.NUM_DIGITS(5), .CHANNELS(6)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(i_valid[1]), .in_ready(rdy1), .in_chan(i_chan[1]), .in_data(i_data[1]),
        .out_valid(vld1), .out_chan(ch1), .out_bcd(bcd1), .out_ovf(ovf1),
        .rd_chan(rd_chan[1]), .rd_bcd(rbcd1), .rd_ovf(rovf1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         idx;
        logic [2:0] chan;
        logic [11:0] data;
        logic [23:0] exp_bcd;
        logic       exp_ovf;
        logic       exp_banked;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [23:0] ref_bcd(input logic [11:0] d);
        longint q;
        logic [23:0] r;
        q = (longint'(d) * 500000) / 4095;
        r = '0;
        for (int k = 0; k < 6; k++) begin
            r[4*k +: 4] = 4'(q % 10);
            q = q / 10;
        end
        return r;
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        int lat;
        lat = 0;
        chk($sformatf("v%0d_ready", id), 32'(o_ready[v.idx]), 1);
        i_chan[v.idx]  = v.chan;
        i_data[v.idx]  = v.data;
        i_valid[v.idx] = 1'b1;
        @(posedge clk); #1;
        i_valid[v.idx] = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (o_valid[v.idx]) begin
                lat = n;
                break;
            end
        end
        chk($sformatf("v%0d_latency", id), lat, 52);
        chk($sformatf("v%0d_out_bcd", id), 32'(o_bcd[v.idx]), 32'(v.exp_bcd));
        chk($sformatf("v%0d_out_ovf", id), 32'(o_ovf[v.idx]), 32'(v.exp_ovf));
        chk($sformatf("v%0d_out_chan", id), 32'(o_chan[v.idx]), 32'(v.chan));
        rd_chan[v.idx] = v.chan;
        #1;
        chk($sformatf("v%0d_rd_bcd", id), 32'(r_bcd[v.idx]), v.exp_banked ? 32'(v.exp_bcd) : 0);
        chk($sformatf("v%0d_rd_ovf", id), 32'(r_ovf[v.idx]), v.exp_banked ? 32'(v.exp_ovf) : 0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_pulse_width", id), 32'(o_valid[v.idx]), 0);
        chk($sformatf("v%0d_out_hold", id), 32'(o_bcd[v.idx]), 32'(v.exp_bcd));
    endtask

    task automatic chk_bank(input int idx, input logic [2:0] c, input logic [23:0] exp_b, input logic exp_o);
        @(posedge clk); #1;
        rd_chan[idx] = c;
        #1;
        chk($sformatf("bank%0d_ch%0d_bcd", idx, c), 32'(r_bcd[idx]), 32'(exp_b));
        chk($sformatf("bank%0d_ch%0d_ovf", idx, c), 32'(r_ovf[idx]), 32'(exp_o));
    endtask

    logic [23:0] exp_bank0 [8];

    int          acc_cyc [$];
    logic [11:0] acc_dat [$];
    logic [2:0]  acc_ch  [$];
    logic [23:0] res_bcd [$];
    logic [2:0]  res_ch  [$];
    int          viol;
    logic        prev_acc;
    logic        seen;

    initial begin
        //           idx chan  data      exp_bcd     ovf   banked
        vecs[0] = '{0, 3'd3, 12'd4095, 24'h500000, 1'b0, 1'b1};
        vecs[1] = '{0, 3'd0, 12'd2048, 24'h250061, 1'b0, 1'b1};
        vecs[2] = '{0, 3'd1, 12'd1,    24'h000122, 1'b0, 1'b1};
        vecs[3] = '{0, 3'd2, 12'd0,    24'h000000, 1'b0, 1'b1};
        vecs[4] = '{0, 3'd7, 12'd100,  24'h012210, 1'b0, 1'b1};
        vecs[5] = '{0, 3'd5, 12'd2048, 24'h250061, 1'b0, 1'b1};
        vecs[6] = '{1, 3'd4, 12'd4095, 24'h099999, 1'b1, 1'b1};
        vecs[7] = '{1, 3'd4, 12'd100,  24'h012210, 1'b0, 1'b1};
        vecs[8] = '{1, 3'd6, 12'd100,  24'h012210, 1'b0, 1'b0};
        vecs[9] = '{1, 3'd7, 12'd1,    24'h000122, 1'b0, 1'b0};

        reset_n = 1'b0;
        i_valid = '0;
        i_chan  = '0;
        i_data  = '0;
        rd_chan = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d_in_ready", d), 32'(o_ready[d]), 1);
            chk($sformatf("rst%0d_out_valid", d), 32'(o_valid[d]), 0);
            chk($sformatf("rst%0d_out_bcd", d), 32'(o_bcd[d]), 0);
            chk($sformatf("rst%0d_out_ovf", d), 32'(o_ovf[d]), 0);
            chk($sformatf("rst%0d_out_chan", d), 32'(o_chan[d]), 0);
        end
        reset_n = 1'b1;
        chk_bank(0, 3'd3, 24'h0, 1'b0);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        exp_bank0 = '{24'h250061, 24'h000122, 24'h000000, 24'h500000,
                      24'h0, 24'h0, 24'h0, 24'h012210};
        for (int c = 0; c < 8; c++) chk_bank(0, 3'(c), exp_bank0[c], 1'b0);

        // Continuous in_valid with data changing every cycle.
        viol = 0;
        prev_acc = 1'b0;
        for (int cyc = 0; cyc < 230; cyc++) begin
            i_valid[0] = (cyc < 170);
            i_data[0]  = 12'((cyc * 397 + 11) % 4096);
            i_chan[0]  = 3'(cyc % 8);
            @(negedge clk);
            if (prev_acc && o_ready[0]) viol++;
            prev_acc = i_valid[0] && o_ready[0];
            if (prev_acc) begin
                acc_cyc.push_back(cyc);
                acc_dat.push_back(i_data[0]);
                acc_ch.push_back(i_chan[0]);
            end
            if (o_valid[0]) begin
                res_bcd.push_back(o_bcd[0]);
                res_ch.push_back(o_chan[0]);
            end
            @(posedge clk); #1;
        end
        i_valid[0] = 1'b0;
        chk("stream_accepts", acc_cyc.size(), 4);
        chk("stream_results", res_bcd.size(), acc_cyc.size());
        chk("stream_ready_drop", viol, 0);
        for (int k = 0; k < acc_cyc.size() && k < res_bcd.size(); k++) begin
            chk($sformatf("stream%0d_bcd", k), 32'(res_bcd[k]), 32'(ref_bcd(acc_dat[k])));
            chk($sformatf("stream%0d_chan", k), 32'(res_ch[k]), 32'(acc_ch[k]));
            if (k > 0) chk($sformatf("stream%0d_spacing", k), acc_cyc[k] - acc_cyc[k-1], 53);
        end

        // Reset in the middle of the divide on channel 5.
        i_chan[0]  = 3'd5;
        i_data[0]  = 12'd4095;
        i_valid[0] = 1'b1;
        @(posedge clk); #1;
        i_valid[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(o_ready[0]), 1);
        chk("midrst_out_valid", 32'(o_valid[0]), 0);
        chk("midrst_out_bcd", 32'(o_bcd[0]), 0);
        chk("midrst_out_chan", 32'(o_chan[0]), 0);
        for (int c = 0; c < 8; c++) chk_bank(0, 3'(c), 24'h0, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (60) begin
            @(posedge clk); #1;
            if (o_valid[0]) seen = 1'b1;
        end
        chk("midrst_no_pulse", 32'(seen), 0);
        chk("midrst_ready_after", 32'(o_ready[0]), 1);
        run_vec(5, vecs[5]);

        // Five-digit instance: saturation, recovery, out-of-range channels.
        for (int i = 6; i < 10; i++) run_vec(i, vecs[i]);
        for (int c = 0; c < 8; c++) chk_bank(1, 3'(c), (c == 4) ? 24'h012210 : 24'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_scale_bcd.md
Name: adc_scale_bcd

Overview:
- Multi-channel, parametrised ADC code-to-decimal scaler.
- Accepts one raw ADC sample at a time over a valid/ready handshake and computes floor(code*FULL_SCALE/(2^ADC_W-1)).
- Converts the result to packed BCD iteratively: sequential divider followed by shift-add-3. No combinational divide.
- Keeps a per-channel result bank so the 7-segment display logic can read any channel's last value at any time. Sits between the ADC sequencer and the hex-display decoders.

Parameters:
- ADC_W, 12, ADC code width in bits; full-scale code is 2^ADC_W-1.
- FULL_SCALE, 500000, scaled value produced for full-scale code (5.00000 V in 10 uV units).
- NUM_DIGITS, 6, number of BCD digits output per result.
- CHANNELS, 8, number of channels (result banks); CH_W = max(1, clog2(CHANNELS)).

Ports:
- clk, in, 1, system clock; all state on rising edge.
- reset_n, in, 1, asynchronous, active-low reset.
- in_valid, in, 1, sample present.
- in_ready, out, 1, block can accept a sample; high only in IDLE.
- in_chan, in, CH_W, channel index of sample.
- in_data, in, ADC_W, raw ADC code.
- out_valid, out, 1, one-cycle pulse when a result completes.
- out_chan, out, CH_W, channel of completed result.
- out_bcd, out, 4*NUM_DIGITS, completed result; digit 0 (least significant) in bits [3:0].
- out_ovf, out, 1, result exceeded NUM_DIGITS digits (saturated).
- rd_chan, in, CH_W, bank read select.
- rd_bcd, out, 4*NUM_DIGITS, combinational read of bank[rd_chan].
- rd_ovf, out, 1, overflow flag of bank[rd_chan].

Behaviour:
- Widths:
  - Q_W = clog2(FULL_SCALE+1).
  - P_W = ADC_W + Q_W.
  - Divisor D = 2^ADC_W-1, held as a P_W-bit constant.
- Reset (reset_n low, async):
  - State = IDLE, in_ready=1, out_valid=0, out_chan=0, out_bcd=0, out_ovf=0.
  - All banks and bank ovf flags = 0.
  - In-flight computation is discarded; no out_valid is produced for it.
- FSM: IDLE -> MUL -> DIV -> BCD -> DONE -> IDLE.
  - IDLE:
    - in_ready=1.
    - On in_valid&in_ready, latch in_chan and in_data. Go to MUL.
  - MUL (1 cycle):
    - Product = data*FULL_SCALE, P_W bits, no truncation.
    - Clear remainder and quotient; bit counter = P_W-1.
  - DIV (P_W cycles):
    - Restoring division, one quotient bit per cycle, MSB first.
    - Each cycle: rem = {rem, prod[cnt]}; if rem >= D then rem -= D and qbit=1, else qbit=0.
    - Result is floor. Rounding is not performed.
  - BCD (Q_W cycles):
    - Double-dabble over the low Q_W quotient bits, MSB first.
    - Before each shift, add 3 to every BCD digit >= 5.
    - The BCD shift register is NUM_DIGITS+1 digits wide so that overflow is detectable.
  - DONE (1 cycle):
    - out_valid=1; out_chan = latched chan.
    - If the extra top digit is nonzero (or any quotient bit >= Q_W is set): out_ovf=1 and out_bcd = all digits 9. Otherwise out_ovf=0 and out_bcd = low NUM_DIGITS digits.
    - Write out_bcd and out_ovf to bank[chan] on the same edge.
    - Next state IDLE.
- Latency:
  - Accept edge to out_valid high = P_W + Q_W + 2 cycles.
  - Default: 31+19+2 = 52 cycles.
  - Minimum accept-to-accept spacing = P_W + Q_W + 3 cycles.
- Output hold: out_bcd, out_chan and out_ovf hold their values until the next DONE. out_valid is high for exactly one cycle.
- Busy handling: in_valid while busy is ignored (in_ready=0); there is no queueing.
- Out-of-range channel: in_chan >= CHANNELS is computed and reported on the out_* ports, but no bank is written.
- Read port:
  - rd_bcd/rd_ovf are combinational from the bank registers.
  - rd_chan >= CHANNELS returns 0.
  - On the DONE edge the bank updates, so a read of that channel shows the new value from the following cycle.
- Boundary values:
  - in_data = 0 gives all-zero digits.
  - in_data = 2^ADC_W-1 gives exactly FULL_SCALE.

Test Plan:
- Reset, then chan=3, data=4095 -> out_valid exactly 52 cycles after accept. out_bcd digits 5,0,0,0,0,0 (0x500000), out_ovf=0. rd_chan=3 reads 0x500000.
- data=2048 ch0 -> 0x250061. data=1 ch1 -> 0x000122. data=0 ch2 -> 0x000000. All banks retain their values; out_valid high 1 cycle per result.
- Hold in_valid high continuously with changing data -> in_ready drops after accept. Only samples present in IDLE cycles are taken; no samples are lost or duplicated relative to the accept handshakes.
- Override NUM_DIGITS=5, data=4095 -> out_bcd=0x99999, out_ovf=1, rd_ovf=1 for that channel. Then data=100 -> out_ovf=0, 0x12210.
- Assert reset_n low mid-DIV on channel 5 -> no out_valid pulse; all outputs and banks read 0; in_ready=1 after release. The next sample computes correctly.
- in_chan = CHANNELS (when CHANNELS is not a power of 2, e.g. override 6, chan=6) -> out_valid with correct value. No bank changes; rd_chan=6 returns 0.
